// File: rtl/stream_argmax.sv
// Streaming argmax: accumulates per-channel scores over a packet, then scans channels to find the winner.
// Optional macro STREAM_ARGMAX_SATURATE_EN selects saturating accumulation (default: two's-complement wrap).
module stream_argmax #(
    parameter int VALUE_BITS = 18,
    parameter int CHANNELS   = 10,
    parameter int ACC_BITS   = 24,
    parameter int CLASS_BITS = $clog2(CHANNELS)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic signed [VALUE_BITS-1:0] in_data [CHANNELS],
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic                         in_last,
    output logic        [CLASS_BITS-1:0] out_class,
    output logic signed [ACC_BITS-1:0]   out_score,
    output logic                         out_valid,
    input  logic                         out_ready
);

    localparam int CNT_BITS = $clog2(CHANNELS + 1);

    typedef enum logic [1:0] {ACCUM, SCAN, HOLD} state_t;

    state_t state_reg, state_next;

    logic                       first_reg;
    logic [CNT_BITS-1:0]        scan_cnt_reg;
    logic signed [ACC_BITS-1:0] acc_reg  [CHANNELS];
    logic signed [ACC_BITS-1:0] acc_next [CHANNELS];
    logic signed [ACC_BITS-1:0] rd_score_reg;
    logic signed [ACC_BITS-1:0] best_score_reg;
    logic [CLASS_BITS-1:0]      rd_idx_reg;
    logic [CLASS_BITS-1:0]      best_class_reg;
    logic                       beat;
    logic                       scan_done;

    assign beat      = in_valid && in_ready;
    assign scan_done = (scan_cnt_reg == CNT_BITS'(CHANNELS));

    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
            logic signed [ACC_BITS-1:0] ext;
            logic signed [ACC_BITS-1:0] add_res;

            assign ext = ACC_BITS'(in_data[gi]);
`ifdef STREAM_ARGMAX_SATURATE_EN
            logic signed [ACC_BITS:0] sum;
            assign sum = (ACC_BITS+1)'(acc_reg[gi]) + (ACC_BITS+1)'(ext);
            // Sign bit disagreeing with the extra bit means the true sum left the ACC_BITS range.
            assign add_res = (sum[ACC_BITS] != sum[ACC_BITS-1])
                           ? (sum[ACC_BITS] ? {1'b1, {(ACC_BITS-1){1'b0}}}
                                            : {1'b0, {(ACC_BITS-1){1'b1}}})
                           : sum[ACC_BITS-1:0];
`else
            assign add_res = acc_reg[gi] + ext;
`endif
            assign acc_next[gi] = first_reg ? ext : add_res;
        end
    endgenerate

    // Accumulators are always overwritten by the first beat of a packet, so they carry no reset.
    always_ff @(posedge clk) begin
        if (beat) begin
            acc_reg <= acc_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ACCUM;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ACCUM:   if (beat && in_last) state_next = SCAN;
            SCAN:    if (scan_done)       state_next = HOLD;
            HOLD:    if (out_ready)       state_next = ACCUM;
            default:                      state_next = ACCUM;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_class = '0;
        out_score = '0;
        case (state_reg)
            ACCUM: in_ready = 1'b1;
            HOLD: begin
                out_valid = 1'b1;
                out_class = best_class_reg;
                out_score = best_score_reg;
            end
            default: ;
        endcase
    end

    // Scan is a two-stage pipe: a registered read of acc[cnt] followed by the compare one cycle later,
    // so SCAN spans CHANNELS+1 cycles with the CHANNELS compares in the last CHANNELS of them.
    always_ff @(posedge clk) begin
        if (reset) begin
            first_reg      <= 1'b1;
            scan_cnt_reg   <= '0;
            rd_score_reg   <= '0;
            rd_idx_reg     <= '0;
            best_score_reg <= '0;
            best_class_reg <= '0;
        end else begin
            if (beat) begin
                first_reg <= in_last;
            end
            if (state_reg == ACCUM) begin
                scan_cnt_reg <= '0;
            end else if (state_reg == SCAN) begin
                scan_cnt_reg <= scan_cnt_reg + 1'b1;
                if (!scan_done) begin
                    rd_score_reg <= acc_reg[CLASS_BITS'(scan_cnt_reg)];
                    rd_idx_reg   <= CLASS_BITS'(scan_cnt_reg);
                end
                if (scan_cnt_reg != '0) begin
                    // Channel 0 seeds the running best; strict > keeps the lowest index on ties.
                    if (rd_idx_reg == '0 || rd_score_reg > best_score_reg) begin
                        best_score_reg <= rd_score_reg;
                        best_class_reg <= rd_idx_reg;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_stream_argmax.sv
// Directed self-checking bench for stream_argmax: default instance (ACC_BITS=24) plus an ACC_BITS=18
// instance for the overflow case; expectations follow STREAM_ARGMAX_SATURATE_EN when defined.
module tb_stream_argmax;

    logic clk = 1'b0;
    logic reset;
    logic signed [17:0] in_data [10];
    logic in_valid_a, in_valid_b, in_last, out_ready;

    logic               in_ready_a, out_valid_a;
    logic [3:0]         out_class_a;
    logic signed [23:0] out_score_a;
    logic               in_ready_b, out_valid_b;
    logic [3:0]         out_class_b;
    logic signed [17:0] out_score_b;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    stream_argmax #(.VALUE_BITS(18), .CHANNELS(10), .ACC_BITS(24)) dut_a (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid_a),
        .in_ready(in_ready_a), .in_last(in_last), .out_class(out_class_a),
        .out_score(out_score_a), .out_valid(out_valid_a), .out_ready(out_ready)
    );

    stream_argmax #(.VALUE_BITS(18), .CHANNELS(10), .ACC_BITS(18)) dut_b (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid_b),
        .in_ready(in_ready_b), .in_last(in_last), .out_class(out_class_b),
        .out_score(out_score_b), .out_valid(out_valid_b), .out_ready(out_ready)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_all(input int v);
        for (int i = 0; i < 10; i++) in_data[i] = 18'(v);
    endtask

    task automatic send(input logic last, input bit to_b);
        in_last = last;
        if (to_b) in_valid_b = 1'b1;
        else      in_valid_a = 1'b1;
        tick();
        in_valid_a = 1'b0;
        in_valid_b = 1'b0;
        in_last    = 1'b0;
    endtask

    task automatic wait_out(input bit on_b, input int max_cycles, output int cycles);
        cycles = 0;
        while (!(on_b ? out_valid_b : out_valid_a) && cycles < max_cycles) begin
            tick();
            cycles++;
        end
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        n_checks++; if (in_ready_a !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %0b expected 1", in_ready_a); end
        n_checks++; if (out_valid_a !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %0b expected 0", out_valid_a); end
        n_checks++; if (out_class_a !== 4'd0) begin n_fail++; $display("FAIL reset_out_class: got %0d expected 0", out_class_a); end
        n_checks++; if (out_score_a !== 24'sd0) begin n_fail++; $display("FAIL reset_out_score: got %0d expected 0", out_score_a); end
        $display("txn reset: in_ready=%0b out_valid=%0b", in_ready_a, out_valid_a);
    endtask

    task automatic test_single_peak();
        int cyc;
        set_all(0);
        in_data[3] = 18'sd500;
        send(1'b1, 1'b0);
        n_checks++; if (in_ready_a !== 1'b0) begin n_fail++; $display("FAIL scan_in_ready: got %0b expected 0", in_ready_a); end
        n_checks++; if (out_score_a !== 24'sd0) begin n_fail++; $display("FAIL scan_score_zero: got %0d expected 0", out_score_a); end
        // Beats offered while busy must be ignored.
        set_all(0);
        in_data[0] = 18'sd1000;
        in_valid_a = 1'b1;
        in_last    = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        in_valid_a = 1'b0;
        in_last    = 1'b0;
        wait_out(1'b0, 30, cyc);
        n_checks++; if (cyc + 3 !== 11) begin n_fail++; $display("FAIL peak_latency: got %0d expected 11", cyc + 3); end
        n_checks++; if (out_valid_a !== 1'b1) begin n_fail++; $display("FAIL peak_valid: got %0b expected 1", out_valid_a); end
        n_checks++; if (out_class_a !== 4'd3) begin n_fail++; $display("FAIL peak_class: got %0d expected 3", out_class_a); end
        n_checks++; if (out_score_a !== 24'sd500) begin n_fail++; $display("FAIL peak_score: got %0d expected 500", out_score_a); end
        $display("txn single_peak: class=%0d score=%0d latency=%0d", out_class_a, out_score_a, cyc + 3);
        handshake();
        n_checks++; if (out_valid_a !== 1'b0) begin n_fail++; $display("FAIL peak_release: got %0b expected 0", out_valid_a); end
    endtask

    task automatic test_tie();
        int cyc;
        set_all(-4);
        in_data[2] = 18'sd100;
        in_data[7] = 18'sd100;
        send(1'b1, 1'b0);
        wait_out(1'b0, 30, cyc);
        n_checks++; if (out_class_a !== 4'd2) begin n_fail++; $display("FAIL tie_class: got %0d expected 2", out_class_a); end
        n_checks++; if (out_score_a !== 24'sd100) begin n_fail++; $display("FAIL tie_score: got %0d expected 100", out_score_a); end
        $display("txn tie: class=%0d score=%0d", out_class_a, out_score_a);
        handshake();
    endtask

    task automatic test_multi_beat();
        int cyc;
        set_all(0);
        in_data[5] = 18'sd10;
        in_data[1] = 18'sd25;
        send(1'b0, 1'b0);
        n_checks++; if (in_ready_a !== 1'b1) begin n_fail++; $display("FAIL multi_in_ready: got %0b expected 1", in_ready_a); end
        in_data[1] = 18'sd0;
        send(1'b0, 1'b0);
        send(1'b1, 1'b0);
        wait_out(1'b0, 30, cyc);
        n_checks++; if (out_class_a !== 4'd5) begin n_fail++; $display("FAIL multi_class: got %0d expected 5", out_class_a); end
        n_checks++; if (out_score_a !== 24'sd30) begin n_fail++; $display("FAIL multi_score: got %0d expected 30", out_score_a); end
        $display("txn multi_beat: class=%0d score=%0d", out_class_a, out_score_a);
        handshake();
    endtask

    task automatic test_back_to_back();
        int cyc;
        set_all(-5);
        in_data[9] = -18'sd1;
        send(1'b1, 1'b0);
        wait_out(1'b0, 30, cyc);
        n_checks++; if (out_class_a !== 4'd9) begin n_fail++; $display("FAIL neg_class: got %0d expected 9", out_class_a); end
        n_checks++; if (out_score_a !== -24'sd1) begin n_fail++; $display("FAIL neg_score: got %0d expected -1", out_score_a); end
        // Downstream stalls with a competing beat offered; nothing may move.
        set_all(0);
        in_data[0] = 18'sd777;
        in_valid_a = 1'b1;
        in_last    = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_checks++; if (out_valid_a !== 1'b1) begin n_fail++; $display("FAIL hold_valid[%0d]: got %0b expected 1", i, out_valid_a); end
            n_checks++; if (out_class_a !== 4'd9) begin n_fail++; $display("FAIL hold_class[%0d]: got %0d expected 9", i, out_class_a); end
            n_checks++; if (out_score_a !== -24'sd1) begin n_fail++; $display("FAIL hold_score[%0d]: got %0d expected -1", i, out_score_a); end
            n_checks++; if (in_ready_a !== 1'b0) begin n_fail++; $display("FAIL hold_in_ready[%0d]: got %0b expected 0", i, in_ready_a); end
        end
        in_valid_a = 1'b0;
        in_last    = 1'b0;
        $display("txn hold: class=%0d score=%0d held 5 cycles", out_class_a, out_score_a);
        handshake();
        n_checks++; if (in_ready_a !== 1'b1) begin n_fail++; $display("FAIL b2b_in_ready: got %0b expected 1", in_ready_a); end
        n_checks++; if (out_class_a !== 4'd0) begin n_fail++; $display("FAIL b2b_class_zero: got %0d expected 0", out_class_a); end
        set_all(-1);
        in_data[6] = 18'sd3;
        send(1'b1, 1'b0);
        wait_out(1'b0, 30, cyc);
        n_checks++; if (out_class_a !== 4'd6) begin n_fail++; $display("FAIL b2b_class: got %0d expected 6", out_class_a); end
        n_checks++; if (out_score_a !== 24'sd3) begin n_fail++; $display("FAIL b2b_score: got %0d expected 3", out_score_a); end
        $display("txn back_to_back: class=%0d score=%0d", out_class_a, out_score_a);
        handshake();
    endtask

    task automatic test_overflow();
        int cyc;
        logic [3:0]         exp_class;
        logic signed [17:0] exp_score;
`ifdef STREAM_ARGMAX_SATURATE_EN
        exp_class = 4'd0;
        exp_score = 18'sd131071;
`else
        exp_class = 4'd1;
        exp_score = 18'sd0;
`endif
        set_all(0);
        in_data[0] = 18'sd131071;
        send(1'b0, 1'b1);
        send(1'b1, 1'b1);
        wait_out(1'b1, 30, cyc);
        n_checks++; if (out_class_b !== exp_class) begin n_fail++; $display("FAIL ovf_class: got %0d expected %0d", out_class_b, exp_class); end
        n_checks++; if (out_score_b !== exp_score) begin n_fail++; $display("FAIL ovf_score: got %0d expected %0d", out_score_b, exp_score); end
        $display("txn overflow: class=%0d score=%0d", out_class_b, out_score_b);
        handshake();
    endtask

    task automatic test_reset_in_scan();
        int cyc;
        int stray;
        set_all(0);
        in_data[0] = 18'sd50;
        send(1'b1, 1'b0);
        for (int i = 0; i < 3; i++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_checks++; if (in_ready_a !== 1'b1) begin n_fail++; $display("FAIL rst_scan_in_ready: got %0b expected 1", in_ready_a); end
        stray = 0;
        for (int i = 0; i < 15; i++) begin
            if (out_valid_a) stray++;
            tick();
        end
        n_checks++; if (stray !== 0) begin n_fail++; $display("FAIL rst_scan_aborted: got %0d valid cycles expected 0", stray); end
        set_all(0);
        in_data[4] = 18'sd7;
        send(1'b1, 1'b0);
        wait_out(1'b0, 30, cyc);
        n_checks++; if (out_class_a !== 4'd4) begin n_fail++; $display("FAIL rst_scan_class: got %0d expected 4", out_class_a); end
        n_checks++; if (out_score_a !== 24'sd7) begin n_fail++; $display("FAIL rst_scan_score: got %0d expected 7", out_score_a); end
        $display("txn reset_in_scan: class=%0d score=%0d", out_class_a, out_score_a);
        handshake();
        stray = 0;
        for (int i = 0; i < 15; i++) begin
            if (out_valid_a) stray++;
            tick();
        end
        n_checks++; if (stray !== 0) begin n_fail++; $display("FAIL rst_scan_single_result: got %0d valid cycles expected 0", stray); end
    endtask

    initial begin
        reset      = 1'b1;
        in_valid_a = 1'b0;
        in_valid_b = 1'b0;
        in_last    = 1'b0;
        out_ready  = 1'b0;
        set_all(0);
        test_reset();
        test_single_peak();
        test_tie();
        test_multi_beat();
        test_back_to_back();
        test_overflow();
        test_reset_in_scan();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
